// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : multi-cycle ALU with shift-add multiply and optional restoring
//           divider (enable with macro ALU_DIV_EN).   Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             Zero,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_ADDU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nx;

  // acc: product HI / partial remainder; quo: multiplier / dividend -> quotient
  logic [WIDTH-1:0] acc, quo, dvs;
  logic [CNT_W-1:0] cnt;
  logic             neg_lo;

  logic is_mul, is_iter, signed_op;
  assign is_mul = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_MULTU);

`ifdef ALU_DIV_EN
  logic is_div;
  logic neg_hi, div_op, div0;
  assign is_div    = (ALUCtrl == OP_DIV) || (ALUCtrl == OP_DIVU);
  assign is_iter   = is_mul || is_div;
  assign signed_op = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_DIV);
`else
  assign is_iter   = is_mul;
  assign signed_op = (ALUCtrl == OP_MULT);
`endif

  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (signed_op && A[WIDTH-1]) ? -A : A;
  assign mag_b = (signed_op && B[WIDTH-1]) ? -B : B;

  // Single-cycle result path
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUCtrl)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_NOR:  alu_res = ~(A | B);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_res = '0;
    endcase
  end

  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, dvs} : '0);

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  assign div_sh  = {acc, quo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, dvs};
  assign div_sub = div_sh[WIDTH-1:0] - dvs;
`endif

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_lo, fix_hi;

  always_comb begin
    prod   = neg_lo ? -{acc, quo} : {acc, quo};
    fix_lo = prod[WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
    // Divide by zero forces an all-ones quotient regardless of sign
    if (div_op) begin
      fix_lo = div0 ? '1 : (neg_lo ? -quo : quo);
      fix_hi = neg_hi ? -acc : acc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:     if (start && is_iter) state_nx = is_mul ? MUL : DIV;
      MUL, DIV: if (cnt == CNT_ONE) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      out      <= '0;
      hi       <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      acc      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
`ifdef ALU_DIV_EN
      neg_hi   <= 1'b0;
      div_op   <= 1'b0;
      div0     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_iter) begin
              acc    <= '0;
              quo    <= mag_a;
              dvs    <= mag_b;
              cnt    <= CNT_INIT;
              neg_lo <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_DIV_EN
              neg_hi <= signed_op && A[WIDTH-1];
              div_op <= is_div;
              div0   <= (B == '0);
`endif
            end else begin
              out      <= alu_res;
              Zero     <= (alu_res == '0);
              Overflow <= alu_ovf;
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_sum[WIDTH:1];
          quo <= {mul_sum[0], quo[WIDTH-1:1]};
          cnt <= cnt - CNT_ONE;
        end
`ifdef ALU_DIV_EN
        DIV: begin
          acc <= div_ge ? div_sub : div_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_ge};
          cnt <= cnt - CNT_ONE;
        end
`endif
        FIX: begin
          out      <= fix_lo;
          hi       <= fix_hi;
          Zero     <= (fix_lo == '0);
          Overflow <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32); expectations adapt to ALU_DIV_EN.
`default_nettype none

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  ALUCtrl = '0;
  logic        busy, done, Zero, Overflow;
  logic [31:0] out, hi;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = '0;

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ALUCtrl(ALUCtrl),
    .busy(busy), .done(done), .out(out), .hi(hi), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        iter;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hprev);
    exp_t e;
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.out = '0; e.hi = hprev; e.ovf = 1'b0; e.iter = 1'b0;
    case (op)
      4'd0: e.out = a & b;
      4'd1: e.out = a | b;
      4'd2: e.out = a ^ b;
      4'd3: e.out = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: begin s = sa + sb; e.out = s[31:0]; e.ovf = (s > SMAX) || (s < SMIN); end
      4'd5: e.out = a + b;
      4'd6: begin s = sa - sb; e.out = s[31:0]; e.ovf = (s > SMAX) || (s < SMIN); end
      4'd7: e.out = ~(a | b);
      4'd8: e.out = (a < b) ? 32'd1 : 32'd0;
      4'd9: begin s = sa * sb; p = s; e.out = p[31:0]; e.hi = p[63:32]; e.iter = 1'b1; end
      4'd10: begin p = {32'd0, a} * {32'd0, b}; e.out = p[31:0]; e.hi = p[63:32]; e.iter = 1'b1; end
`ifdef ALU_DIV_EN
      4'd11: begin
        e.iter = 1'b1;
        if (b == 0) begin e.out = '1; e.hi = a; end
        else begin s = sa / sb; e.out = s[31:0]; s = sa % sb; e.hi = s[31:0]; end
      end
      4'd12: begin
        e.iter = 1'b1;
        if (b == 0) begin e.out = '1; e.hi = a; end
        else begin e.out = a / b; e.hi = a % b; end
      end
`endif
      default: e.out = '0;
    endcase
    e.zero = (e.out == 0);
    return e;
  endfunction

  // Issue one op in the current cycle and follow it to done.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    exp_t e;
    int n;
    e = model(op, a, b, model_hi);
    start = 1'b1; ALUCtrl = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; ALUCtrl = 4'($urandom);
    n = 0;
    check("busy_after_start", {63'd0, busy}, {63'd0, e.iter});
    while (!done && n < 100) begin
      if (poke && n == 10) begin start = 1'b1; ALUCtrl = 4'b0100; end
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", 64'(n), e.iter ? 64'd33 : 64'd0);
    check("out", {32'd0, out}, {32'd0, e.out});
    check("hi", {32'd0, hi}, {32'd0, e.hi});
    check("zero", {63'd0, Zero}, {63'd0, e.zero});
    check("ovf", {63'd0, Overflow}, {63'd0, e.ovf});
    check("busy_at_done", {63'd0, busy}, 64'd0);
    model_hi = e.hi;
  endtask

  logic [31:0] corners [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_out", {32'd0, out}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_zero", {63'd0, Zero}, 64'd0);
    check("rst_ovf", {63'd0, Overflow}, 64'd0);

    run_op(4'b0100, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(4'b0101, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(4'b0110, 32'd5, 32'd5, 1'b0);
    run_op(4'b0110, 32'h8000_0000, 32'd1, 1'b0);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(4'b1001, 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    run_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(4'b1011, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(4'b1011, 32'd7, 32'd0, 1'b0);
    run_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(4'b1011, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(4'b1100, 32'd9, 32'd3, 1'b0);
    run_op(4'b1111, 32'd1, 32'd2, 1'b0);

    // Reset in the middle of a multiply
    start = 1'b1; ALUCtrl = 4'b1001; A = 32'd1234; B = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_busy", {63'd0, busy}, 64'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_out", {32'd0, out}, 64'd0);
    check("mid_rst_hi", {32'd0, hi}, 64'd0);
    model_hi = '0;
    run_op(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
